// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl
//   Sequences one operand tile from SRAM into the N-lane input skew array that
//   feeds the systolic array. It issues K consecutive SRAM row reads, then
//   drains the skew array for N-1 zero-filled cycles, then spends one flush
//   cycle so the last row can leave lane N-1. Finally it pulses done.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           tile request, only honoured in IDLE
//   base_addr       first SRAM row, captured on an accepted start
//   num_rows        row count K, captured on an accepted start
//   stall           downstream hold; freezes READ/DRAIN sequencing
//   sram_ren_n      SRAM read enable (active-low)
//   sram_addr       SRAM row address (wraps modulo 2^ADDR_W)
//   sa_ren_n        skew array read enable (active-low)
//   zero_fill       datapath forces skew array data_in to zero this cycle
//   lane_valid      bit i: skewed lane i carries real row data this cycle
//   busy            tile in progress
//   done            one-cycle completion pulse
module skew_feed_ctrl #(
  parameter int N      = 8,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_rows,
  input  logic              stall,
  output logic              sram_ren_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sa_ren_n,
  output logic              zero_fill,
  output logic [N-1:0]      lane_valid,
  output logic              busy,
  output logic              done
);

  localparam int                 DRAIN_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(N - 1);
  localparam bit                 SKIP_DRAIN = (N == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [N-1:0]        h_q, h_d;
  logic [N-1:0]        lane_valid_q, lane_valid_d;
  logic                zero_fill_q, zero_fill_d;

  logic                issue_read_s;
  logic                issue_drain_s;
  logic                sram_ren_n_s;
  logic                sa_ren_n_s;
  logic                busy_s;
  logic                done_s;
  logic [N-1:0]        h_next_s;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      k_q          <= '0;
      row_q        <= '0;
      drain_q      <= '0;
      h_q          <= '0;
      lane_valid_q <= '0;
      zero_fill_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      k_q          <= k_d;
      row_q        <= row_d;
      drain_q      <= drain_d;
      h_q          <= h_d;
      lane_valid_q <= lane_valid_d;
      zero_fill_q  <= zero_fill_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_rows == '0) ? S_FIN : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (!stall && (row_q == k_q - CNT_W'(1))) begin
          state_d = SKIP_DRAIN ? S_FIN : S_DRAIN;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        // Once N-1 drain cycles are issued, one more non-stalled cycle lets
        // the final row leave lane N-1 before done is raised.
        if (!stall && (drain_q == DRAIN_LAST)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: enables react to stall in the same cycle
  always_comb begin
    issue_read_s  = 1'b0;
    issue_drain_s = 1'b0;
    sram_ren_n_s  = 1'b1;
    sa_ren_n_s    = 1'b1;
    busy_s        = 1'b0;
    done_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_s = 1'b0;
      end
      S_READ: begin
        busy_s = 1'b1;
        if (!stall) begin
          issue_read_s = 1'b1;
          sram_ren_n_s = 1'b0;
          sa_ren_n_s   = 1'b0;
        end else begin
          issue_read_s = 1'b0;
        end
      end
      S_DRAIN: begin
        busy_s = 1'b1;
        if (!stall && (drain_q != DRAIN_LAST)) begin
          issue_drain_s = 1'b1;
          sa_ren_n_s    = 1'b0;
        end else begin
          issue_drain_s = 1'b0;
        end
      end
      S_FIN: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Address, row/drain counters and tile capture
  always_comb begin
    addr_d  = addr_q;
    k_d     = k_q;
    row_d   = row_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          k_d     = num_rows;
          row_d   = '0;
          drain_d = '0;
        end else begin
          addr_d  = addr_q;
        end
      end
      S_READ: begin
        if (issue_read_s) begin
          addr_d = addr_q + ADDR_W'(1);
          row_d  = row_q + CNT_W'(1);
        end else begin
          row_d  = row_q;
        end
      end
      S_DRAIN: begin
        if (issue_drain_s) begin
          drain_d = drain_q + DRAIN_W'(1);
        end else begin
          drain_d = drain_q;
        end
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  // Valid history: shifts only on cycles where the skew array is enabled,
  // so lane i of a row becomes valid i enabled cycles after its issue.
  always_comb begin
    h_next_s    = (h_q << 32'd1) | N'(issue_read_s);
    zero_fill_d = issue_drain_s;
    if (!sa_ren_n_s) begin
      h_d          = h_next_s;
      lane_valid_d = h_next_s;
    end else begin
      h_d          = h_q;
      lane_valid_d = '0;
    end
  end

  assign sram_ren_n = sram_ren_n_s;
  assign sa_ren_n   = sa_ren_n_s;
  assign sram_addr  = addr_q;
  assign zero_fill  = zero_fill_q;
  assign lane_valid = lane_valid_q;
  assign busy       = busy_s;
  assign done       = done_s;

endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Testbench for skew_feed_ctrl: directed tiles from the test plan plus random
// tiles with random stalls, compared cycle by cycle against a slot-based
// reference timeline computed in the bench.
module tb_skew_feed_ctrl;

  localparam int N    = 8;
  localparam int AW   = 10;
  localparam int CW   = 10;
  localparam int MAXC = 400;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_rows;
  logic          stall;
  logic          sram_ren_n;
  logic [AW-1:0] sram_addr;
  logic          sa_ren_n;
  logic          zero_fill;
  logic [N-1:0]  lane_valid;
  logic          busy;
  logic          done;

  skew_feed_ctrl #(.N(N), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .stall      (stall),
    .sram_ren_n (sram_ren_n),
    .sram_addr  (sram_addr),
    .sa_ren_n   (sa_ren_n),
    .zero_fill  (zero_fill),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit            stall_pat [MAXC];
  logic          exp_sram_n[MAXC];
  logic          exp_sa_n  [MAXC];
  logic          exp_zf    [MAXC];
  logic          exp_busy  [MAXC];
  logic          exp_done  [MAXC];
  logic [AW-1:0] exp_addr  [MAXC];
  logic [N-1:0]  exp_lv    [MAXC];
  int            tfin_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
  endtask

  task automatic random_stalls();
    for (int i = 0; i < MAXC; i++)
      stall_pat[i] = (i < 200) ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // Reference timeline. Start is accepted in cycle 0. A tile with K>0 needs
  // K read slots, N-1 drain slots and one flush slot, each consuming one
  // non-stalled cycle from cycle 1 on; done follows the flush slot. A row
  // issued at enable slot j shows up on lane i in the cycle after enable
  // slot j+i.
  task automatic build_model(input logic [AW-1:0] base, input int k);
    int en_list[$];
    int slot;
    int total;
    int t;
    for (int c = 0; c < MAXC; c++) begin
      exp_sram_n[c] = 1'b1;
      exp_sa_n[c]   = 1'b1;
      exp_zf[c]     = 1'b0;
      exp_busy[c]   = 1'b0;
      exp_done[c]   = 1'b0;
      exp_addr[c]   = '0;
      exp_lv[c]     = '0;
    end
    if (k == 0) begin
      tfin_m = 1;
    end else begin
      total = k + N;
      slot  = 0;
      t     = 1;
      while (slot < total) begin
        if (!stall_pat[t]) begin
          if (slot < k) begin
            exp_sram_n[t] = 1'b0;
            exp_sa_n[t]   = 1'b0;
            exp_addr[t]   = base + AW'(slot);
            en_list.push_back(t);
          end else if (slot < k + N - 1) begin
            exp_sa_n[t]   = 1'b0;
            exp_zf[t + 1] = 1'b1;
            en_list.push_back(t);
          end
          slot++;
        end
        t++;
      end
      tfin_m = t;
      for (int j = 0; j < k; j++)
        for (int i = 0; i < N; i++)
          exp_lv[en_list[j + i] + 1][i] = 1'b1;
    end
    for (int c = 1; c < tfin_m; c++) exp_busy[c] = 1'b1;
    exp_done[tfin_m] = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_sram_ren_n"}, 32'(sram_ren_n), 32'd1);
    chk({pfx, "_sa_ren_n"},   32'(sa_ren_n),   32'd1);
    chk({pfx, "_zero_fill"},  32'(zero_fill),  32'd0);
    chk({pfx, "_sram_addr"},  32'(sram_addr),  32'd0);
    chk({pfx, "_lane_valid"}, 32'(lane_valid), 32'd0);
    chk({pfx, "_busy"},       32'(busy),       32'd0);
    chk({pfx, "_done"},       32'(done),       32'd0);
  endtask

  // Runs one tile, cycle 0 being the start cycle. extra pulses ignored
  // starts (with other base/K) at cycle 2 and in the done cycle; rst_cyc>=0
  // asserts reset in that cycle and checks reset values in the next one.
  task automatic run_tile(input logic [AW-1:0] base, input int k, input bit extra,
                          input int rst_cyc, output int done_at);
    build_model(base, k);
    done_at = -1;
    for (int t = 0; t <= tfin_m; t++) begin
      @(posedge clk);
      #1;
      start     = (t == 0) || (extra && ((t == 2) || (t == tfin_m)));
      base_addr = (t == 0) ? base : ~base;
      num_rows  = (t == 0) ? CW'(k) : CW'(k + 5);
      stall     = stall_pat[t];
      rst       = (t == rst_cyc);
      #1;
      if ((done === 1'b1) && (done_at < 0)) done_at = t;
      chk($sformatf("sram_ren_n@%0d", t), 32'(sram_ren_n), 32'(exp_sram_n[t]));
      chk($sformatf("sa_ren_n@%0d", t),   32'(sa_ren_n),   32'(exp_sa_n[t]));
      chk($sformatf("zero_fill@%0d", t),  32'(zero_fill),  32'(exp_zf[t]));
      chk($sformatf("lane_valid@%0d", t), 32'(lane_valid), 32'(exp_lv[t]));
      chk($sformatf("busy@%0d", t),       32'(busy),       32'(exp_busy[t]));
      chk($sformatf("done@%0d", t),       32'(done),       32'(exp_done[t]));
      if (exp_sram_n[t] == 1'b0)
        chk($sformatf("sram_addr@%0d", t), 32'(sram_addr), 32'(exp_addr[t]));
      if (t == rst_cyc) begin
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        stall = 1'($urandom_range(0, 1));
        #1;
        if (done === 1'b1) done_at = t + 1;
        check_reset_outputs("after_rst");
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    int d;
    logic [AW-1:0] rb;
    int rk;
    bit rx;

    rst       = 1'b1;
    start     = 1'b0;
    stall     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // base 0x010, K=3: done expected at K+N+1 = 12
    clear_stalls();
    run_tile(10'h010, 3, 1'b0, -1, d);
    chk("done_cycle_k3", 32'(d), 32'd12);

    // K=0: straight to done in cycle 1, with stall high during start
    clear_stalls();
    stall_pat[0] = 1'b1;
    run_tile(10'h155, 0, 1'b0, -1, d);
    chk("done_cycle_k0", 32'(d), 32'd1);

    // K=4 with stall on cycles 2-3: done delayed from 13 to 15
    clear_stalls();
    stall_pat[2] = 1'b1;
    stall_pat[3] = 1'b1;
    run_tile(10'h020, 4, 1'b0, -1, d);
    chk("done_cycle_stall", 32'(d), 32'd15);

    // Address wrap 0x3FE..0x001
    clear_stalls();
    run_tile(10'h3FE, 4, 1'b0, -1, d);
    chk("done_cycle_wrap", 32'(d), 32'd13);

    // Reset in the middle of DRAIN (reads 1-5, drain 6-12): no done
    clear_stalls();
    run_tile(10'h040, 5, 1'b0, 8, d);
    chk("no_done_after_rst", 32'(d), 32'hFFFF_FFFF);

    // New tile 2 cycles after the reset runs normally
    clear_stalls();
    run_tile(10'h100, 3, 1'b0, -1, d);
    chk("done_cycle_post_rst", 32'(d), 32'd12);

    // Starts while busy and in the done cycle are ignored
    clear_stalls();
    run_tile(10'h200, 6, 1'b1, -1, d);
    chk("done_cycle_extra_start", 32'(d), 32'd15);

    // Back-to-back random tiles with random stalls
    for (int n = 0; n < 12; n++) begin
      random_stalls();
      rb = AW'($urandom);
      rk = $urandom_range(0, 24);
      rx = 1'($urandom_range(0, 1));
      run_tile(rb, rk, rx, -1, d);
      chk($sformatf("done_cycle_rand%0d", n), 32'(d), 32'(tfin_m));
    end

    @(posedge clk);
    #1;
    start = 1'b0;
    stall = 1'b0;
    #1;
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_done", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
